// File: rtl/data_mem_be_if.sv
// data_mem_be_if: request/response bus for the byte-enable data memory.
//   master drives req, memRead, memWrite, address, writeData, byteEn;
//   slave drives ready, readData, readValid, err.
interface data_mem_be_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                    req;
    logic                    memRead;
    logic                    memWrite;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   writeData;
    logic [DATA_WIDTH/8-1:0] byteEn;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   readData;
    logic                    readValid;
    logic                    err;

    modport master (
        output req, memRead, memWrite, address, writeData, byteEn,
        input  ready, readData, readValid, err
    );

    modport slave (
        input  req, memRead, memWrite, address, writeData, byteEn,
        output ready, readData, readValid, err
    );
endinterface

// File: rtl/data_mem_be.sv
// data_mem_be: word memory with per-byte write enables, self-clearing after reset.
//   CLK  clock, RST asynchronous active-high reset
//   bus  slave side of data_mem_be_if (request in, ready/readData/readValid/err out)
module data_mem_be #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input logic         CLK,
    input logic         RST,
    data_mem_be_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] IDLE = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state;
    logic [ADDR_WIDTH-1:0] clearIdx;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  inRange;
    logic                  doRead;
    logic                  doWrite;

    assign bus.ready = state == IDLE;
    assign accept    = bus.req && bus.ready;
    // Extra top bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    assign inRange   = {1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH);
    assign doRead    = accept && bus.memRead;
    assign doWrite   = accept && bus.memWrite && !bus.memRead;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= INIT;
            clearIdx      <= '0;
            bus.readData  <= '0;
            bus.readValid <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.readValid <= doRead && inRange;
            bus.err       <= (doRead || doWrite) && !inRange;
            if (doRead && inRange)
                bus.readData <= mem[bus.address];
            if (state == INIT) begin
                clearIdx <= clearIdx == LAST ? '0 : clearIdx + 1'b1;
                state    <= clearIdx == LAST ? IDLE : INIT;
            end
        end
    end

    // Storage has no reset of its own; INIT sweeps it to zero one word per cycle.
    always_ff @(posedge CLK) begin
        if (state == INIT)
            mem[clearIdx] <= '0;
        else if (doWrite && inRange)
            for (int i = 0; i < NB; i++)
                if (bus.byteEn[i])
                    mem[bus.address][8*i +: 8] <= bus.writeData[8*i +: 8];
    end
endmodule
